// File: rtl/jk_exciter.sv
// Stimulus engine for a JK flip-flop: turns a stream of target bits into J/K
// excitation pairs, then checks the flip-flop's fed-back Qn against each target.
module jk_exciter #(
  parameter int CNT_W   = 8,
  parameter bit DC_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             jk_j,
  output logic             jk_k,
  input  logic             q_fb,
  output logic             busy,
  output logic             match,
  output logic             mismatch,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic             DC      = DC_MODE;

  state_t           state, state_next;
  logic             target, target_next;
  logic             q_model, q_model_next;
  logic             j_next, k_next;
  logic             match_next, mismatch_next;
  logic [CNT_W-1:0] xfer_next, err_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      target   <= 1'b0;
      q_model  <= 1'b0;
      jk_j     <= 1'b0;
      jk_k     <= 1'b0;
      match    <= 1'b0;
      mismatch <= 1'b0;
      xfer_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_next;
      target   <= target_next;
      q_model  <= q_model_next;
      jk_j     <= j_next;
      jk_k     <= k_next;
      match    <= match_next;
      mismatch <= mismatch_next;
      xfer_cnt <= xfer_next;
      err_cnt  <= err_next;
    end
  end

  // J/K default to 0,0 so the flip-flop holds in every cycle except DRIVE.
  always_comb begin
    state_next    = state;
    target_next   = target;
    q_model_next  = q_model;
    j_next        = 1'b0;
    k_next        = 1'b0;
    match_next    = 1'b0;
    mismatch_next = 1'b0;
    xfer_next     = xfer_cnt;
    err_next      = err_cnt;
    case (state)
      IDLE: begin
        if (tgt_valid) begin
          target_next = tgt_bit;
          state_next  = DRIVE;
          if (!q_model) begin
            j_next = tgt_bit;
            k_next = DC;
          end else begin
            j_next = DC;
            k_next = !tgt_bit;
          end
        end
      end
      DRIVE: begin
        state_next = CHECK;
      end
      CHECK: begin
        state_next    = IDLE;
        q_model_next  = q_fb;
        match_next    = (q_fb == target);
        mismatch_next = (q_fb != target);
        if (xfer_cnt != CNT_MAX) xfer_next = xfer_cnt + CNT_ONE;
        if ((q_fb != target) && (err_cnt != CNT_MAX)) err_next = err_cnt + CNT_ONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign tgt_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_jk_exciter.sv
// Bench for jk_exciter: two instances (DC_MODE 0 with 4-bit counters, DC_MODE 1
// with 8-bit counters), each driving a behavioural JK flip-flop.
module tb_jk_exciter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tgt_valid = 1'b0;
  logic tgt_bit = 1'b0;
  logic stuck = 1'b0;

  logic       ready_a, j_a, k_a, busy_a, match_a, mismatch_a, q_a, q_fb_a;
  logic [3:0] xfer_a, err_a;
  logic       ready_b, j_b, k_b, busy_b, match_b, mismatch_b, q_b, q_fb_b;
  logic [7:0] xfer_b, err_b;

  int total = 0;
  int bad = 0;
  int xa = 0, ea = 0, xb = 0, eb = 0;
  logic qexp = 1'b0;
  time acc_t = 0;

  typedef struct {
    logic tgt;
    logic ja, ka, jb, kb;
  } vec_t;

  typedef struct {
    logic tgt, qfb;
    logic ja, ka, jb, kb;
  } sb_t;

  vec_t vecs[5];
  sb_t  sbq[$];

  always #5 clk = ~clk;

  jk_exciter #(.CNT_W(4), .DC_MODE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(ready_a), .jk_j(j_a), .jk_k(k_a), .q_fb(q_fb_a), .busy(busy_a),
    .match(match_a), .mismatch(mismatch_a), .xfer_cnt(xfer_a), .err_cnt(err_a)
  );

  jk_exciter #(.CNT_W(8), .DC_MODE(1'b1)) dut_b (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(ready_b), .jk_j(j_b), .jk_k(k_b), .q_fb(q_fb_b), .busy(busy_b),
    .match(match_b), .mismatch(mismatch_b), .xfer_cnt(xfer_b), .err_cnt(err_b)
  );

  // Behavioural JK flip-flops; stuck forces the fed-back Qn low.
  always @(posedge clk) begin
    if (reset) begin
      q_a <= 1'b0;
      q_b <= 1'b0;
    end else begin
      case ({j_a, k_a})
        2'b01: q_a <= 1'b0;
        2'b10: q_a <= 1'b1;
        2'b11: q_a <= ~q_a;
        default: q_a <= q_a;
      endcase
      case ({j_b, k_b})
        2'b01: q_b <= 1'b0;
        2'b10: q_b <= 1'b1;
        2'b11: q_b <= ~q_b;
        default: q_b <= q_b;
      endcase
    end
  end

  assign q_fb_a = stuck ? 1'b0 : q_a;
  assign q_fb_b = stuck ? 1'b0 : q_b;

  function automatic logic [1:0] excite(input logic q, input logic t, input logic dc);
    case ({q, t})
      2'b00:   return {1'b0, dc};
      2'b01:   return {1'b1, dc};
      2'b10:   return {dc, 1'b1};
      default: return {dc, 1'b0};
    endcase
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, {ready_a, ready_b}, 2'b11);
    checkOutput({tag, "_busy"}, {busy_a, busy_b}, 2'b00);
    checkOutput({tag, "_jk"}, {j_a, k_a, j_b, k_b}, 4'b0000);
    checkOutput({tag, "_pulses"}, {match_a, mismatch_a, match_b, mismatch_b}, 4'b0000);
    checkOutput({tag, "_cnt_a"}, {xfer_a, err_a}, 0);
    checkOutput({tag, "_cnt_b"}, {xfer_b, err_b}, 0);
  endtask

  task automatic resetDuts();
    @(posedge clk);
    #1 reset = 1'b1;
    tgt_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    checkResetState("reset");
    xa = 0; ea = 0; xb = 0; eb = 0;
    qexp = 1'b0;
    sbq.delete();
  endtask

  // Offers one target, follows it through DRIVE and CHECK, comparing every cycle.
  task automatic applyStimulus(input logic b, input logic [1:0] jka, input logic [1:0] jkb,
                               input bit keep);
    sb_t e;
    bit m;
    int w;
    e.tgt = b;
    e.qfb = stuck ? 1'b0 : b;
    {e.ja, e.ka} = jka;
    {e.jb, e.kb} = jkb;
    sbq.push_back(e);
    tgt_valid = 1'b1;
    tgt_bit = b;
    w = 0;
    @(negedge clk);
    while (!(ready_a && ready_b) && w < 10) begin
      w++;
      @(negedge clk);
    end
    checkOutput("ready_idle", {ready_a, ready_b}, 2'b11);
    @(posedge clk);
    acc_t = $time;
    #1;
    e = sbq.pop_front();
    checkOutput("drive_jk_a", {j_a, k_a}, {e.ja, e.ka});
    checkOutput("drive_jk_b", {j_b, k_b}, {e.jb, e.kb});
    checkOutput("drive_ready", {ready_a, ready_b, busy_a, busy_b}, 4'b0011);
    if (!keep) tgt_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("check_jk", {j_a, k_a, j_b, k_b}, 4'b0000);
    checkOutput("check_ready", {ready_a, ready_b, busy_a, busy_b}, 4'b0011);
    checkOutput("check_pulses", {match_a, mismatch_a, match_b, mismatch_b}, 4'b0000);
    @(posedge clk);
    #1;
    m = (e.qfb == e.tgt);
    xa = (xa == 15) ? 15 : xa + 1;
    xb = (xb == 255) ? 255 : xb + 1;
    if (!m) begin
      ea = (ea == 15) ? 15 : ea + 1;
      eb = (eb == 255) ? 255 : eb + 1;
    end
    qexp = e.qfb;
    checkOutput("done_ready", {ready_a, ready_b, busy_a, busy_b}, 4'b1100);
    checkOutput("pulse_a", {match_a, mismatch_a}, {m, !m});
    checkOutput("pulse_b", {match_b, mismatch_b}, {m, !m});
    checkOutput("xfer_a", xfer_a, xa);
    checkOutput("err_a", err_a, ea);
    checkOutput("xfer_b", xfer_b, xb);
    checkOutput("err_b", err_b, eb);
  endtask

  task automatic sendAuto(input logic b, input bit keep);
    applyStimulus(b, excite(qexp, b, 1'b0), excite(qexp, b, 1'b1), keep);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    time prev;
    vecs[0] = '{tgt: 1'b1, ja: 1'b1, ka: 1'b0, jb: 1'b1, kb: 1'b1};
    vecs[1] = '{tgt: 1'b1, ja: 1'b0, ka: 1'b0, jb: 1'b1, kb: 1'b0};
    vecs[2] = '{tgt: 1'b0, ja: 1'b0, ka: 1'b1, jb: 1'b1, kb: 1'b1};
    vecs[3] = '{tgt: 1'b0, ja: 1'b0, ka: 1'b0, jb: 1'b0, kb: 1'b1};
    vecs[4] = '{tgt: 1'b1, ja: 1'b1, ka: 1'b0, jb: 1'b1, kb: 1'b1};

    resetDuts();
    for (int i = 0; i < 5; i++)
      applyStimulus(vecs[i].tgt, {vecs[i].ja, vecs[i].ka}, {vecs[i].jb, vecs[i].kb}, 1'b0);

    // Stuck-at-0 feedback: both transfers mismatch, second still drives J=1.
    resetDuts();
    stuck = 1'b1;
    applyStimulus(1'b1, 2'b10, 2'b11, 1'b0);
    applyStimulus(1'b1, 2'b10, 2'b11, 1'b0);
    checkOutput("stuck_err_a", err_a, 2);
    stuck = 1'b0;

    resetDuts();
    for (int i = 0; i < 20; i++)
      sendAuto(1'($urandom_range(0, 1)), 1'b0);
    checkOutput("sat_xfer_a", xfer_a, 15);
    checkOutput("sat_xfer_b", xfer_b, 20);

    // Reset landing on the edge that ends DRIVE drops the transfer.
    tgt_valid = 1'b1;
    tgt_bit = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    tgt_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    checkResetState("rst_drive");
    @(posedge clk);
    #1;
    checkResetState("rst_drive_after");
    xa = 0; ea = 0; xb = 0; eb = 0;
    qexp = 1'b0;
    applyStimulus(1'b1, 2'b10, 2'b11, 1'b0);

    // Continuous valid with alternating bits: one accept every three cycles.
    resetDuts();
    for (int i = 0; i < 6; i++) begin
      prev = acc_t;
      sendAuto(1'(i % 2 == 0), 1'b1);
      if (i > 0) checkOutput("accept_spacing", int'(acc_t - prev), 30);
    end
    tgt_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
